// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } lsu_state_t;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/lsu_extend.sv
// Lane select and sign/zero extension of a read word for loads.
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  addr,
  input  mem_size_t   size,
  input  logic        is_unsigned,
  output logic [31:0] ext
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = mem_rdata[{addr, 3'b000} +: 8];
    lane_h = addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size)
      SZ_BYTE: ext = {{24{~is_unsigned & lane_b[7]}}, lane_b};
      SZ_HALF: ext = {{16{~is_unsigned & lane_h[15]}}, lane_h};
      default: ext = mem_rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: stalling request/ready transaction on the data-memory port
// with byte lanes, load extension, misalignment and bus-timeout reporting.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemReq,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic        MemUnsigned,
  input  logic [31:0] ALUout,
  input  logic [31:0] WriteData,
  output logic        Stall,
  output logic        Done,
  output logic [31:0] LoadData,
  output logic        MisalignErr,
  output logic        BusErr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  lsu_state_t  state;
  logic [CW-1:0] cnt;
  mem_size_t   size_q;
  logic        uns_q;
  logic [1:0]  off_q;
  logic [31:0] ext;

  mem_size_t   size_in;
  logic        bad;
  logic [3:0]  be;
  logic [31:0] wd;

  always_comb begin
    size_in = mem_size_t'(MemSize);
    be      = BE_WORD;
    wd      = WriteData;
    bad     = 1'b0;
    case (size_in)
      SZ_BYTE: begin
        be = BE_BYTE << ALUout[1:0];
        wd = {4{WriteData[7:0]}};
      end
      SZ_HALF: begin
        be  = BE_HALF << {ALUout[1], 1'b0};
        wd  = {2{WriteData[15:0]}};
        bad = ALUout[0];
      end
      SZ_WORD: bad = (ALUout[1:0] != 2'b00);
      default: bad = 1'b1;
    endcase
  end

  // Accept cycle stalls combinationally; BUS stalls for its whole duration.
  assign Stall = (state == BUS) || ((state == IDLE) && MemReq);

  lsu_extend u_extend (
    .mem_rdata   (mem_rdata),
    .addr        (off_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .ext         (ext)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      size_q      <= SZ_BYTE;
      uns_q       <= 1'b0;
      off_q       <= '0;
      Done        <= 1'b0;
      LoadData    <= '0;
      MisalignErr <= 1'b0;
      BusErr      <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_be      <= '0;
      mem_wdata   <= '0;
    end else begin
      Done        <= 1'b0;
      MisalignErr <= 1'b0;
      BusErr      <= 1'b0;
      case (state)
        IDLE: begin
          LoadData <= '0;
          if (MemReq) begin
            if (bad) begin
              state       <= RESP;
              Done        <= 1'b1;
              MisalignErr <= 1'b1;
            end else begin
              state     <= BUS;
              cnt       <= '0;
              mem_req   <= 1'b1;
              mem_we    <= MemWrite;
              mem_addr  <= {ALUout[31:2], 2'b00};
              mem_be    <= be;
              mem_wdata <= wd;
              size_q    <= size_in;
              uns_q     <= MemUnsigned;
              off_q     <= ALUout[1:0];
            end
          end
        end
        BUS: begin
          if (mem_ready) begin
            state    <= RESP;
            mem_req  <= 1'b0;
            Done     <= 1'b1;
            LoadData <= mem_we ? '0 : ext;
          end else if (cnt == LAST) begin
            state   <= RESP;
            mem_req <= 1'b0;
            Done    <= 1'b1;
            BusErr  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          LoadData <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed test-plan cases plus random accesses
// compared against an arithmetic reference model of lanes, enables and extension.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MemReq = 1'b0, MemWrite = 1'b0, MemUnsigned = 1'b0;
  logic [1:0]  MemSize = 2'b00;
  logic [31:0] ALUout = '0, WriteData = '0;
  logic        Stall, Done, MisalignErr, BusErr;
  logic [31:0] LoadData;
  logic        mem_req, mem_we, mem_ready = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic [3:0]  mem_be;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  localparam int TO = 16;

  lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .MemReq(MemReq), .MemWrite(MemWrite),
    .MemSize(MemSize), .MemUnsigned(MemUnsigned), .ALUout(ALUout),
    .WriteData(WriteData), .Stall(Stall), .Done(Done), .LoadData(LoadData),
    .MisalignErr(MisalignErr), .BusErr(BusErr), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] rd, input int off,
                                           input int size, input bit uns);
    logic [31:0] v;
    if (size == 0) begin
      v = (rd >> (off * 8)) & 32'hFF;
      if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (size == 1) begin
      v = (rd >> ((off / 2) * 16)) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic logic [3:0] ref_be(input int off, input int size);
    if (size == 0) return 4'(1 << off);
    if (size == 1) return 4'(3 << ((off / 2) * 2));
    return 4'hF;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] w, input int size);
    if (size == 0) return (w & 32'hFF) * 32'h0101_0101;
    if (size == 1) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  // ready_at: BUS-cycle index (0-based) at which mem_ready is asserted; -1 never
  task automatic access(input bit we, input int size, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int ready_at, input logic [31:0] rdata);
    int  off = int'(addr[1:0]);
    bit  mis = (size == 3) || (size == 1 && off % 2 != 0) || (size == 2 && off != 0);
    int  bus_n = 0, stall_n = 0;
    bit  done_seen = 0;
    int  exp_bus = mis ? 0 : ((ready_at < 0 || ready_at >= TO) ? TO : ready_at + 1);
    bit  exp_berr = !mis && (ready_at < 0 || ready_at >= TO);
    MemReq = 1'b1; MemWrite = we; MemSize = 2'(size); MemUnsigned = uns;
    ALUout = addr; WriteData = wdata; mem_rdata = rdata;
    for (int c = 0; c < 60 && !done_seen; c++) begin
      mem_ready = mem_req && (bus_n == ready_at);
      @(negedge clk);
      if (mem_req) begin
        if (bus_n == 0) begin
          check("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
          check("mem_be", 32'(mem_be), 32'(ref_be(off, size)));
          check("mem_we", 32'(mem_we), 32'(we));
          if (we) check("mem_wdata", mem_wdata, ref_wdata(wdata, size));
        end
        bus_n++;
      end
      if (Stall) stall_n++;
      if (Done) begin
        done_seen = 1;
        check("stall_cycles", stall_n, 1 + exp_bus);
        check("bus_cycles", bus_n, exp_bus);
        check("misalign", 32'(MisalignErr), 32'(mis));
        check("buserr", 32'(BusErr), 32'(exp_berr));
        check("loaddata", LoadData,
              (we || mis || exp_berr) ? 32'h0 : ref_load(rdata, off, size, uns));
      end
      @(posedge clk); #1;
    end
    if (!done_seen) check("done_timeout", 32'd0, 32'd1);
    MemReq = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    check("done_pulse", 32'(Done), 32'd0);
    check("req_idle", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int sz, rdy;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_stall", 32'(Stall), 0);
    check("rst_done", 32'(Done), 0);
    check("rst_loaddata", LoadData, 0);
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_be", 32'(mem_be), 0);
    check("rst_mem_wdata", mem_wdata, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    access(0, 2, 0, 32'h100, 0, 0, 32'hDEAD_BEEF);
    access(0, 0, 0, 32'h103, 0, 0, 32'h80FF_FF7F);
    access(0, 0, 1, 32'h103, 0, 0, 32'h80FF_FF7F);
    access(0, 0, 0, 32'h100, 0, 0, 32'h80FF_FF7F);
    access(1, 1, 0, 32'h102, 32'h1234_ABCD, 0, 0);
    access(0, 2, 0, 32'h101, 0, 0, 32'h1111_1111);
    access(0, 3, 0, 32'h100, 0, 0, 32'h1111_1111);
    access(0, 2, 0, 32'h104, 0, -1, 32'h2222_2222);
    access(0, 2, 0, 32'h108, 0, TO - 1, 32'h3333_3333);
    access(0, 1, 0, 32'h10A, 0, 2, 32'h8001_7FFE);

    // abandon an access with a one-cycle reset while waiting in BUS
    MemReq = 1'b1; MemWrite = 1'b0; MemSize = 2'b10; ALUout = 32'h300; mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0; MemReq = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_req", 32'(mem_req), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_mid_done", 32'(Done), 0);
    end
    @(posedge clk); #1;
    access(0, 2, 0, 32'h200, 0, 1, 32'hCAFE_F00D);

    for (int t = 0; t < 40; t++) begin
      sz  = $urandom_range(0, 9) == 0 ? 3 : int'($urandom_range(0, 2));
      rdy = $urandom_range(0, 9) == 0 ? -1 : int'($urandom_range(0, 3));
      access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
             $urandom, $urandom, rdy, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the execute→memory boundary of the RISC-V core. Consumes the ALU result as the effective address, plus the store data and funct3 size/sign information. Runs a stalling request/ready transaction on the data-memory port, handling byte/half/word lanes, byte enables, load extension, misalignment and bus timeout. Returns the load result to writeback and holds the pipeline while busy.

## Interface
- `TIMEOUT_CYCLES`, default 16: number of BUS-state cycles before abort. Must be ≥1.
- `clk` in 1: single clock; everything is on the rising edge.
- `rst_n` in 1: reset; synchronous and active-low.
- `MemReq` in 1: the execute stage holds a load or store.
- `MemWrite` in 1: 1 for store, 0 for load.
- `MemSize` in 2: funct3[1:0]; 00 byte, 01 half, 10 word, 11 illegal.
- `MemUnsigned` in 1: funct3[2]; zero-extend the load.
- `ALUout` in 32: effective byte address.
- `WriteData` in 32: rs2 store data.
- `Stall` out 1: freezes the pipeline.
- `Done` out 1: one-cycle completion pulse.
- `LoadData` out 32: extended load result, valid while `Done` is high.
- `MisalignErr` out 1: pulses with `Done` for misaligned or illegal access.
- `BusErr` out 1: pulses with `Done` on timeout.
- `mem_req` out 1: bus request.
- `mem_we` out 1: bus write.
- `mem_addr` out 32: word-aligned address, `{ALUout[31:2],2'b00}`.
- `mem_be` out 4: byte enables.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_ready` in 1: bus completes the access in this cycle.
- `mem_rdata` in 32: read word, valid when `mem_ready` is high.

## Operation
- States:
  - IDLE: wait for a request.
  - BUS: request active on the bus.
  - RESP: report completion.
- IDLE, `MemReq`=1, aligned → latch address, size, sign, we, be and wdata; go to BUS.
  - `Stall`=1 combinationally in this cycle.
- IDLE, `MemReq`=1, misaligned or `MemSize`=11 → go to RESP with the misalign flag latched; no bus access.
  - `Stall`=1 in this cycle.
  - Misaligned means: half with addr[0]=1; word with addr[1:0]≠0.
- BUS:
  - `mem_req`=1 and `Stall`=1; all `mem_*` outputs come from registers and stay stable.
  - `mem_ready`=1 → latch the extended `mem_rdata` (loads only) and go to RESP.
  - Else increment the wait counter. In the `TIMEOUT_CYCLES`th BUS cycle with `mem_ready`=0 → latch the bus-error flag and go to RESP.
  - `mem_ready` in that final cycle counts as success.
- RESP:
  - Outputs: `Done`=1, `Stall`=0, error flags as latched.
  - `LoadData` = latched value; it is 0 for stores and errors.
  - Next state is IDLE unconditionally. `MemReq` is still high in RESP (same instruction) and is not re-accepted; the pipeline advances at the end of RESP.
- Byte enables:
  - byte: `4'b0001<<addr[1:0]`
  - half: `4'b0011<<{addr[1],1'b0}`
  - word: `4'b1111`
- Store data replication:
  - byte: `{4{WriteData[7:0]}}`
  - half: `{2{WriteData[15:0]}}`
  - word: unchanged.
- Loads:
  - Select the lane by address; sign-extend, or zero-extend if `MemUnsigned`=1.
  - Word loads ignore `MemUnsigned`.
- Upstream must hold all inputs stable while `Stall`=1; the block samples them only in IDLE.

## Timing
- Reset values: all outputs 0 (`Stall`, `Done`, `LoadData`, both errors, `mem_req`, `mem_we`, `mem_addr`, `mem_be`, `mem_wdata`); state IDLE; counter 0.
- Reset mid-transaction: `mem_req` falls at the edge where `rst_n`=0 is sampled. No `Done` is produced and the access is abandoned.
- Best-case latency (ready on the first BUS cycle):
  - `Stall` high for 2 cycles (IDLE accept, BUS).
  - `Done` in the 3rd cycle, counted from the cycle `MemReq` is seen.
- Each extra `mem_ready`-low cycle adds 1 cycle.
- Misaligned access: `Stall` for 1 cycle, `Done` in the next cycle.
- Timeout: `mem_req` high for exactly `TIMEOUT_CYCLES` cycles, then `Done` with `BusErr`.
- `Done`, `MisalignErr` and `BusErr` never stay high for more than 1 cycle.
- Back-to-back accesses: the earliest next accept is the cycle after RESP.

## Structure
- `lsu_pkg`:
  - `mem_size_t` enum: `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`, `SZ_ILL`.
  - `lsu_state_t` enum: IDLE/BUS/RESP.
  - Byte-enable base constants.
- Sub-module `lsu_extend`, combinational:
  - Inputs: `mem_rdata`, addr[1:0], size, unsigned.
  - Output: the 32-bit extended load value.
  - Instantiated once, ahead of the `LoadData` register.
- FSM, wait counter (width `$clog2(TIMEOUT_CYCLES+1)`) and latch registers live in `lsu`.

## Test plan
- Word load at `ALUout`=0x100:
  - Response: `mem_ready`=1 on the first BUS cycle with `mem_rdata`=0xDEADBEEF.
  - Required: `mem_addr`=0x100, `mem_be`=1111; `Stall` high 2 cycles; then `Done`=1 and `LoadData`=0xDEADBEEF.
- Byte load at 0x103 with `mem_rdata`=0x80FF_FF7F:
  - `MemUnsigned`=0 → `LoadData`=0xFFFFFF80.
  - `MemUnsigned`=1 → `LoadData`=0x00000080.
  - Repeat the signed case at 0x100 → 0x0000007F.
- Half store at 0x102, `WriteData`=0x1234ABCD:
  - Required: `mem_addr`=0x100, `mem_be`=1100, `mem_wdata`=0xABCDABCD, `mem_we`=1; `LoadData`=0 on `Done`.
- Word load at 0x101:
  - Required: `mem_req` never rises; next cycle `Done`=1 and `MisalignErr`=1, `LoadData`=0.
  - Repeat with `MemSize`=11 at 0x100 → same response.
- `mem_ready` tied 0, `TIMEOUT_CYCLES`=16:
  - Required: `mem_req` high exactly 16 cycles; then `Done`=1, `BusErr`=1, `LoadData`=0.
  - Variant: `mem_ready`=1 in the 16th BUS cycle → normal completion with `BusErr`=0.
- `rst_n`=0 for 1 cycle while in BUS with `mem_ready`=0:
  - Required: `mem_req`=0 after that edge; no `Done` pulse.
  - A following word load at 0x200 completes normally.
